// File: rtl/chnl_rx_driver_if.sv
// Channel-side bundle between the RX driver and a RIFFA user channel module,
// plus the command port used to launch transfers.
interface chnl_rx_driver_if #(
    parameter int C_PCI_DATA_WIDTH = 128
);
    logic                        CMD_VALID;
    logic                        CMD_READY;
    logic [31:0]                 CMD_LEN;
    logic [30:0]                 CMD_OFF;
    logic                        CMD_LAST;
    logic [31:0]                 CMD_SEED;
    logic                        CHNL_RX;
    logic                        CHNL_RX_ACK;
    logic                        CHNL_RX_LAST;
    logic [31:0]                 CHNL_RX_LEN;
    logic [30:0]                 CHNL_RX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
    logic                        CHNL_RX_DATA_VALID;
    logic                        CHNL_RX_DATA_REN;
    logic                        DONE;
    logic                        TIMEOUT;

    modport master (
        input  CMD_VALID, CMD_LEN, CMD_OFF, CMD_LAST, CMD_SEED,
        input  CHNL_RX_ACK, CHNL_RX_DATA_REN,
        output CMD_READY, CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
        output CHNL_RX_DATA, CHNL_RX_DATA_VALID, DONE, TIMEOUT
    );

    modport slave (
        output CMD_VALID, CMD_LEN, CMD_OFF, CMD_LAST, CMD_SEED,
        output CHNL_RX_ACK, CHNL_RX_DATA_REN,
        input  CMD_READY, CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
        input  CHNL_RX_DATA, CHNL_RX_DATA_VALID, DONE, TIMEOUT
    );
endinterface

// File: rtl/chnl_rx_driver.sv
// Stand-in for the RIFFA endpoint on one RX channel: requests a transaction,
// waits for ACK, then streams an incrementing word pattern under REN control.
module chnl_rx_driver #(
    parameter int C_PCI_DATA_WIDTH = 128,
    parameter int C_ACK_TIMEOUT    = 1024
) (
    input  logic              CLK,
    input  logic              RST_N,
    chnl_rx_driver_if.master  bus
);
    localparam int N     = C_PCI_DATA_WIDTH / 32;
    localparam int SHIFT = (N == 4) ? 2 : ((N == 2) ? 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                      r_state;
    logic                        r_cmd_ready;
    logic                        r_rx;
    logic                        r_last;
    logic [31:0]                 r_len;
    logic [30:0]                 r_off;
    logic [C_PCI_DATA_WIDTH-1:0] r_data;
    logic                        r_valid;
    logic                        r_done;
    logic                        r_timeout;
    logic [31:0]                 r_beats_left;
    logic [31:0]                 r_base;
    logic [2:0]                  r_last_lanes;
    logic [31:0]                 r_tmo_cnt;

    logic [32:0]                 w_sum;
    logic [31:0]                 w_beats;
    logic [1:0]                  w_rem;
    logic [2:0]                  w_last_lanes;

    // Lanes at or beyond nvalid are forced to zero (short final beat).
    function automatic logic [C_PCI_DATA_WIDTH-1:0] make_beat(
        input logic [31:0] base,
        input logic [2:0]  nvalid
    );
        logic [C_PCI_DATA_WIDTH-1:0] beat;
        beat = '0;
        for (int i = 0; i < N; i++) begin
            if (3'(i) < nvalid) begin
                beat[32*i +: 32] = base + 32'(i);
            end else begin
                beat[32*i +: 32] = 32'd0;
            end
        end
        return beat;
    endfunction

    // Beat count and final-beat lane count from the incoming command length.
    always_comb begin
        w_sum   = {1'b0, bus.CMD_LEN} + 33'(N - 1);
        w_beats = 32'(w_sum >> SHIFT);
        w_rem   = bus.CMD_LEN[1:0] & 2'(N - 1);
        if (w_rem == 2'd0) begin
            w_last_lanes = 3'(N);
        end else begin
            w_last_lanes = {1'b0, w_rem};
        end
    end

    // Main FSM; every output is a register updated alongside the state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b1;
            r_rx         <= 1'b0;
            r_last       <= 1'b0;
            r_len        <= 32'd0;
            r_off        <= 31'd0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_beats_left <= 32'd0;
            r_base       <= 32'd0;
            r_last_lanes <= 3'd0;
            r_tmo_cnt    <= 32'd0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.CMD_VALID) begin
                        r_len        <= bus.CMD_LEN;
                        r_off        <= bus.CMD_OFF;
                        r_last       <= bus.CMD_LAST;
                        r_base       <= bus.CMD_SEED;
                        r_beats_left <= w_beats;
                        r_last_lanes <= w_last_lanes;
                        r_tmo_cnt    <= 32'd0;
                        r_cmd_ready  <= 1'b0;
                        r_rx         <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.CHNL_RX_ACK) begin
                        if (r_beats_left != 32'd0) begin
                            r_valid <= 1'b1;
                            r_data  <= make_beat(r_base, (r_beats_left == 32'd1) ? r_last_lanes : 3'(N));
                            r_base  <= r_base + 32'(N);
                            r_state <= S_XFER;
                        end else begin
                            r_rx    <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end else if ((C_ACK_TIMEOUT != 0) && (r_tmo_cnt == 32'(C_ACK_TIMEOUT - 1))) begin
                        r_rx        <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
                end
                S_XFER: begin
                    if (r_valid && bus.CHNL_RX_DATA_REN) begin
                        if (r_beats_left == 32'd1) begin
                            r_rx    <= 1'b0;
                            r_valid <= 1'b0;
                            r_data  <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_beats_left <= r_beats_left - 32'd1;
                            r_data       <= make_beat(r_base, (r_beats_left == 32'd2) ? r_last_lanes : 3'(N));
                            r_base       <= r_base + 32'(N);
                        end
                    end
                end
                S_FIN: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_rx        <= 1'b0;
                    r_valid     <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.CMD_READY          = r_cmd_ready;
    assign bus.CHNL_RX            = r_rx;
    assign bus.CHNL_RX_LAST       = r_last;
    assign bus.CHNL_RX_LEN        = r_len;
    assign bus.CHNL_RX_OFF        = r_off;
    assign bus.CHNL_RX_DATA       = r_data;
    assign bus.CHNL_RX_DATA_VALID = r_valid;
    assign bus.DONE               = r_done;
    assign bus.TIMEOUT            = r_timeout;
endmodule

// File: tb/tb_chnl_rx_driver.sv
// Directed bench for chnl_rx_driver at 128-bit width with a 16-cycle ACK timeout.
module tb_chnl_rx_driver;
    localparam int W = 128;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    chnl_rx_driver_if #(.C_PCI_DATA_WIDTH(W)) bus ();

    chnl_rx_driver #(
        .C_PCI_DATA_WIDTH(W),
        .C_ACK_TIMEOUT   (16)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations gathered by run_cmd for the calling test to compare.
    logic [W-1:0] got_beat [0:15];
    int           got_n, rx_cycles, valid_cycles, done_cnt, tmo_cnt, hold_bad;
    int           done_cyc, last_beat_cyc;
    logic         run_ok, ready_after, post_pulse, tmo_rx, tmo_ready;
    logic [31:0]  cap_len;
    logic [30:0]  cap_off;
    logic         cap_last;

    task automatic run_cmd(input logic [31:0] len, input logic [30:0] off, input logic last,
                           input logic [31:0] seed, input int ack_delay,
                           input logic [6:0] pat, input int pat_len);
        logic         acked, finishing, stop, prev_valid, prev_ren, ren;
        logic [W-1:0] prev_data;
        int           pidx, cyc;
        got_n = 0; rx_cycles = 0; valid_cycles = 0; done_cnt = 0; tmo_cnt = 0;
        hold_bad = 0; done_cyc = -1; last_beat_cyc = -1; run_ok = 1'b0;
        ready_after = 1'b0; post_pulse = 1'b0; tmo_rx = 1'b1; tmo_ready = 1'b0;
        cap_len = 32'd0; cap_off = 31'd0; cap_last = 1'b0;
        acked = 1'b0; finishing = 1'b0; stop = 1'b0; prev_valid = 1'b0; prev_ren = 1'b0;
        prev_data = '0; pidx = 0; cyc = 0;
        @(negedge clk);
        bus.CMD_LEN = len; bus.CMD_OFF = off; bus.CMD_LAST = last; bus.CMD_SEED = seed;
        bus.CMD_VALID = 1'b1;
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
        while (!stop && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            bus.CHNL_RX_ACK = 1'b0;
            if (finishing) begin
                ready_after = bus.CMD_READY;
                post_pulse  = bus.DONE | bus.TIMEOUT;
                run_ok      = 1'b1;
                stop        = 1'b1;
            end else begin
                if (bus.CHNL_RX) begin
                    rx_cycles++;
                    if (rx_cycles == 1) begin
                        cap_len = bus.CHNL_RX_LEN; cap_off = bus.CHNL_RX_OFF; cap_last = bus.CHNL_RX_LAST;
                    end
                end
                if (bus.DONE) begin done_cnt++; done_cyc = cyc; finishing = 1'b1; end
                if (bus.TIMEOUT) begin
                    tmo_cnt++; tmo_rx = bus.CHNL_RX; tmo_ready = bus.CMD_READY; finishing = 1'b1;
                end
                if (bus.CHNL_RX_DATA_VALID) begin
                    valid_cycles++;
                    if (prev_valid && !prev_ren && bus.CHNL_RX_DATA !== prev_data) hold_bad++;
                    ren = (pidx < pat_len) ? pat[pidx] : 1'b1;
                    pidx++;
                    bus.CHNL_RX_DATA_REN = ren;
                    if (ren && got_n < 16) begin
                        got_beat[got_n] = bus.CHNL_RX_DATA;
                        got_n++;
                        last_beat_cyc = cyc;
                    end
                end else begin
                    bus.CHNL_RX_DATA_REN = 1'b1;
                end
                prev_valid = bus.CHNL_RX_DATA_VALID;
                prev_ren   = bus.CHNL_RX_DATA_REN;
                prev_data  = bus.CHNL_RX_DATA;
                if (bus.CHNL_RX && !bus.CHNL_RX_DATA_VALID && !acked && ack_delay > 0 && rx_cycles == ack_delay) begin
                    bus.CHNL_RX_ACK = 1'b1;
                    acked = 1'b1;
                end
            end
            cyc++;
        end
        bus.CHNL_RX_ACK = 1'b0;
        bus.CHNL_RX_DATA_REN = 1'b0;
        n_total++;
        if (run_ok !== 1'b1) $display("FAIL run_complete: got %b want 1 (no DONE/TIMEOUT in budget)", run_ok);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.CMD_VALID = 1'b0; bus.CMD_LEN = 32'd0; bus.CMD_OFF = 31'd0; bus.CMD_LAST = 1'b0;
        bus.CMD_SEED = 32'd0; bus.CHNL_RX_ACK = 1'b0; bus.CHNL_RX_DATA_REN = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus.CMD_READY, bus.CHNL_RX, bus.CHNL_RX_DATA_VALID, bus.DONE, bus.TIMEOUT} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b want 10000", {bus.CMD_READY, bus.CHNL_RX, bus.CHNL_RX_DATA_VALID, bus.DONE, bus.TIMEOUT});
        else n_pass++;
        n_total++;
        if ({bus.CHNL_RX_LEN, bus.CHNL_RX_OFF, bus.CHNL_RX_LAST, bus.CHNL_RX_DATA} !== '0)
            $display("FAIL reset_fields: len %h off %h last %b data %h want all zero",
                     bus.CHNL_RX_LEN, bus.CHNL_RX_OFF, bus.CHNL_RX_LAST, bus.CHNL_RX_DATA);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_cmd(32'd8, 31'd0, 1'b0, 32'd0, 3, 7'b1111111, 7);
        n_total++;
        if (got_n !== 2) $display("FAIL basic_beats: got %0d want 2", got_n); else n_pass++;
        n_total++;
        if (got_beat[0] !== 128'h00000003_00000002_00000001_00000000)
            $display("FAIL basic_beat0: got %h want 00000003000000020000000100000000", got_beat[0]);
        else n_pass++;
        n_total++;
        if (got_beat[1] !== 128'h00000007_00000006_00000005_00000004)
            $display("FAIL basic_beat1: got %h want 00000007000000060000000500000004", got_beat[1]);
        else n_pass++;
        n_total++;
        if (rx_cycles !== 5) $display("FAIL basic_rx_cycles: got %0d want 5", rx_cycles); else n_pass++;
        n_total++;
        if (done_cnt !== 1 || done_cyc !== last_beat_cyc + 1)
            $display("FAIL basic_done: count %0d at %0d want 1 at %0d", done_cnt, done_cyc, last_beat_cyc + 1);
        else n_pass++;
        n_total++;
        if (ready_after !== 1'b1 || post_pulse !== 1'b0)
            $display("FAIL basic_after: ready %b pulse %b want 1 0", ready_after, post_pulse);
        else n_pass++;
    endtask

    task automatic test_partial;
        run_cmd(32'd5, 31'h1234567, 1'b1, 32'h100, 1, 7'b1111111, 7);
        n_total++;
        if (cap_len !== 32'd5 || cap_off !== 31'h1234567 || cap_last !== 1'b1)
            $display("FAIL partial_fields: len %h off %h last %b want 5 1234567 1", cap_len, cap_off, cap_last);
        else n_pass++;
        n_total++;
        if (got_n !== 2 || got_beat[0] !== 128'h00000103_00000102_00000101_00000100)
            $display("FAIL partial_beat0: n %0d got %h want 00000103000001020000010100000100", got_n, got_beat[0]);
        else n_pass++;
        n_total++;
        if (got_beat[1] !== 128'h00000000_00000000_00000000_00000104)
            $display("FAIL partial_beat1: got %h want 00000000000000000000000000000104", got_beat[1]);
        else n_pass++;
    endtask

    task automatic test_ren_stall;
        run_cmd(32'd12, 31'd0, 1'b0, 32'd0, 2, 7'b1011001, 7);
        n_total++;
        if (got_n !== 3) $display("FAIL stall_beats: got %0d want 3", got_n); else n_pass++;
        n_total++;
        if (got_beat[0] !== 128'h00000003_00000002_00000001_00000000 ||
            got_beat[1] !== 128'h00000007_00000006_00000005_00000004 ||
            got_beat[2] !== 128'h0000000b_0000000a_00000009_00000008)
            $display("FAIL stall_order: got %h %h %h want words 0..11", got_beat[0], got_beat[1], got_beat[2]);
        else n_pass++;
        n_total++;
        if (hold_bad !== 0 || valid_cycles !== 5)
            $display("FAIL stall_hold: changes %0d valid cycles %0d want 0 5", hold_bad, valid_cycles);
        else n_pass++;
    endtask

    task automatic test_timeout;
        run_cmd(32'd4, 31'd0, 1'b0, 32'd0, 0, 7'b1111111, 7);
        n_total++;
        if (tmo_cnt !== 1 || rx_cycles !== 16 || done_cnt !== 0)
            $display("FAIL timeout_pulse: tmo %0d rx %0d done %0d want 1 16 0", tmo_cnt, rx_cycles, done_cnt);
        else n_pass++;
        n_total++;
        if (tmo_rx !== 1'b0 || tmo_ready !== 1'b1 || post_pulse !== 1'b0)
            $display("FAIL timeout_state: rx %b ready %b next pulse %b want 0 1 0", tmo_rx, tmo_ready, post_pulse);
        else n_pass++;
        run_cmd(32'd4, 31'd0, 1'b0, 32'd0, 2, 7'b1111111, 7);
        n_total++;
        if (done_cnt !== 1 || got_n !== 1 || got_beat[0] !== 128'h00000003_00000002_00000001_00000000)
            $display("FAIL timeout_recover: done %0d n %0d beat %h want 1 1 00000003000000020000000100000000",
                     done_cnt, got_n, got_beat[0]);
        else n_pass++;
    endtask

    task automatic test_wrap;
        run_cmd(32'd4, 31'd0, 1'b0, 32'hFFFFFFFE, 1, 7'b1111111, 7);
        n_total++;
        if (got_n !== 1 || got_beat[0] !== 128'h00000001_00000000_FFFFFFFF_FFFFFFFE)
            $display("FAIL wrap_beat0: n %0d got %h want 0000000100000000FFFFFFFFFFFFFFFE", got_n, got_beat[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.CMD_LEN = 32'd16; bus.CMD_OFF = 31'h55; bus.CMD_LAST = 1'b1; bus.CMD_SEED = 32'd0;
        bus.CMD_VALID = 1'b1;
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
        bus.CHNL_RX_ACK = 1'b1;
        bus.CHNL_RX_DATA_REN = 1'b1;
        @(negedge clk);
        bus.CHNL_RX_ACK = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.CHNL_RX_DATA_VALID !== 1'b1 || bus.CHNL_RX_DATA !== 128'h00000007_00000006_00000005_00000004)
            $display("FAIL midrst_beat1: valid %b data %h want 1 00000007000000060000000500000004",
                     bus.CHNL_RX_DATA_VALID, bus.CHNL_RX_DATA);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.CMD_READY, bus.CHNL_RX, bus.CHNL_RX_DATA_VALID, bus.DONE, bus.TIMEOUT} !== 5'b10000 ||
            {bus.CHNL_RX_LEN, bus.CHNL_RX_OFF, bus.CHNL_RX_LAST, bus.CHNL_RX_DATA} !== '0)
            $display("FAIL midrst_async: ctrl %b len %h data %h want 10000 and zeros",
                     {bus.CMD_READY, bus.CHNL_RX, bus.CHNL_RX_DATA_VALID, bus.DONE, bus.TIMEOUT},
                     bus.CHNL_RX_LEN, bus.CHNL_RX_DATA);
        else n_pass++;
        bus.CHNL_RX_DATA_REN = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(32'd0, 31'd0, 1'b0, 32'd0, 2, 7'b1111111, 7);
        n_total++;
        if (done_cnt !== 1 || valid_cycles !== 0 || got_n !== 0 || done_cyc !== 2 || rx_cycles !== 2)
            $display("FAIL len0_done: done %0d@%0d valid %0d beats %0d rx %0d want 1@2 0 0 2",
                     done_cnt, done_cyc, valid_cycles, got_n, rx_cycles);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_partial();
        test_ren_stall();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
